// File: rtl/rx_nibble_fifo.sv
// rx_nibble_fifo: packs CDR bits (MSB first) into nibbles and queues them.
// Ports: inClock, inReset (async, low), inWriteEnable/inData (bit strobe),
//   inReadEnable (pop), inFlush (sync clear), outData/outValid (pop result),
//   outCount, outBitCount, outFull, outEmpty, outAlmostFull, outAlmostEmpty,
//   outWriteError (dropped nibble), outReadError (pop on empty).
module rx_nibble_fifo #(
    parameter int DEPTH            = 16,
    parameter int ALMOST_FULL_LVL  = 14,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                     inClock,
    input  logic                     inReset,
    input  logic                     inWriteEnable,
    input  logic                     inData,
    input  logic                     inReadEnable,
    input  logic                     inFlush,
    output logic [3:0]               outData,
    output logic                     outValid,
    output logic [$clog2(DEPTH):0]   outCount,
    output logic [1:0]               outBitCount,
    output logic                     outFull,
    output logic                     outEmpty,
    output logic                     outAlmostFull,
    output logic                     outAlmostEmpty,
    output logic                     outWriteError,
    output logic                     outReadError
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LVL);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [1:0]    bitCnt;
    logic [2:0]    shiftReg;

    logic       nibbleDone;
    logic [3:0] newNibble;
    logic       isFull;
    logic       isEmpty;
    logic       popOk;
    logic       pushOk;

    // A pop in the same cycle frees the slot a full-FIFO push needs;
    // the read of mem[rdPtr] still sees the old contents at that edge.
    always_comb begin
        nibbleDone = inWriteEnable && (bitCnt == 2'd3);
        newNibble  = {shiftReg, inData};
        isFull     = (count == FULL_CNT);
        isEmpty    = (count == '0);
        popOk      = inReadEnable && !isEmpty;
        pushOk     = nibbleDone && (!isFull || popOk);
    end

    always_ff @(posedge inClock) begin
        if (!inFlush && pushOk) begin
            mem[wrPtr] <= newNibble;
        end
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            bitCnt        <= '0;
            shiftReg      <= '0;
            outData       <= '0;
            outValid      <= 1'b0;
            outWriteError <= 1'b0;
            outReadError  <= 1'b0;
        end else if (inFlush) begin
            wrPtr         <= '0;
            rdPtr         <= '0;
            count         <= '0;
            bitCnt        <= '0;
            shiftReg      <= '0;
            outValid      <= 1'b0;
            outWriteError <= 1'b0;
            outReadError  <= 1'b0;
        end else begin
            if (inWriteEnable) begin
                shiftReg <= newNibble[2:0];
                bitCnt   <= bitCnt + 1'b1;
            end
            if (pushOk) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popOk) begin
                outData <= mem[rdPtr];
                rdPtr   <= rdPtr + 1'b1;
            end
            if (pushOk && !popOk) begin
                count <= count + 1'b1;
            end else if (popOk && !pushOk) begin
                count <= count - 1'b1;
            end
            outValid      <= popOk;
            outWriteError <= nibbleDone && !pushOk;
            outReadError  <= inReadEnable && isEmpty;
        end
    end

    assign outCount       = count;
    assign outBitCount    = bitCnt;
    assign outFull        = isFull;
    assign outEmpty       = isEmpty;
    assign outAlmostFull  = (count >= AF_CNT);
    assign outAlmostEmpty = (count <= AE_CNT);

endmodule

// File: doc/rx_nibble_fifo.md
Name: rx_nibble_fifo

Overview:
Receive-side deserializing FIFO at the end of the demodulation chain (decoder → CORDIC → CDR → here). It is the counterpart of the transmit FIFO, which turns nibbles into a bit stream for the MSK modulator. This block collects recovered bits from the CDR (data plus flag strobe) into 4-bit nibbles and buffers them for the host read port. The CDR cannot be back-pressured, so overflow drops data and is flagged.

Parameters:
DEPTH, 16, number of nibble entries; power of two, ≥4
ALMOST_FULL_LVL, 14, outAlmostFull asserts when count ≥ this value
ALMOST_EMPTY_LVL, 2, outAlmostEmpty asserts when count ≤ this value

Ports:
inClock  in  1  single clock, rising edge
inReset  in  1  asynchronous, active-low reset
inWriteEnable  in  1  bit strobe from CDR (o_flag); one bit per high cycle
inData  in  1  recovered bit from CDR (o_data)
inReadEnable  in  1  pop request from host
inFlush  in  1  synchronous clear of FIFO and partial nibble
outData  out  4  last popped nibble, registered
outValid  out  1  one-cycle pulse: outData updated this cycle
outCount  out  log2(DEPTH)+1  stored nibbles, 0..DEPTH
outBitCount  out  2  bits held in the partial nibble, 0..3
outFull  out  1  count == DEPTH
outEmpty  out  1  count == 0
outAlmostFull  out  1  count ≥ ALMOST_FULL_LVL
outAlmostEmpty  out  1  count ≤ ALMOST_EMPTY_LVL
outWriteError  out  1  one-cycle pulse: nibble dropped on full
outReadError  out  1  one-cycle pulse: pop attempted on empty

Behaviour:
- Reset (inReset=0, async):
  - pointers, count, bit counter, shift register cleared.
  - outData=0, outValid=0, errors=0, outFull=0, outAlmostFull=0.
  - outEmpty=1, outAlmostEmpty=1.
  - Memory contents are not reset.
  - Reset mid-operation discards any partial nibble and all stored nibbles.
- Bit assembly, MSB first:
  - Each inWriteEnable cycle: shift <= {shift[2:0], inData}; bitcnt++.
  - On the 4th bit (bitcnt==3 and inWriteEnable), nibble {shift[2:0], inData} is pushed at that edge; bitcnt wraps to 0.
  - The first received bit becomes nibble bit 3.
- Push latency: outCount/outEmpty update on the edge that captures the 4th bit, visible the next cycle.
- Push on full (no pop that cycle):
  - nibble dropped, outWriteError=1 for one cycle.
  - count and pointers unchanged; bitcnt still wraps to 0, so alignment is kept.
- Pop:
  - inReadEnable with count>0 → outData <= mem[rdptr], outValid=1 next cycle, rdptr++.
  - Latency 1 cycle, registered read.
- Pop on empty → outReadError=1 for one cycle, outValid=0, outData holds.
- Simultaneous push and pop:
  - Count nonzero: both accepted; count unchanged.
  - Full: both accepted, no write error.
  - Empty: push accepted, pop rejected with outReadError (no fall-through).
- Pointers wrap modulo DEPTH.
- Flags are derived from the registered count and are valid in the same cycle as outCount.
- Flush:
  - Priority over push and pop.
  - Clears pointers, count, bitcnt and shift register.
  - outValid=0, errors=0; outData holds.
  - Bits strobed during the flush cycle are discarded.
- outBitCount reflects bitcnt after each edge.
- No combinational path from any input to any output.

Test Plan:
1. After reset, strobe bits 1,0,1,1 → outCount=1, outEmpty=0. Pop → next cycle outData=4'hB, outValid=1 for one cycle, outCount=0.
2. Strobe 8 bits 1,1,0,0,0,0,1,1 with idle gaps between strobes → outCount=2. Two pops → 4'hC then 4'h3.
3. Strobe 64 bits of nibbles 0..F:
   - outAlmostFull rises at count 14; outFull at 16.
   - 4 more bits (4'h5) → outWriteError pulse, count stays 16.
   - Pops return 0..F in order; 4'h5 is never returned.
4. Pop when empty → outReadError pulse, outValid=0, outData unchanged.
5. FIFO full and 4th bit coincides with a pop → pop returns the oldest nibble, the new nibble is stored, count stays 16, no outWriteError.
6. Strobe 2 bits, assert inFlush → outBitCount=0, outCount=0. Strobe 0,1,1,0 → pop returns 4'h6. Repeat with inReset pulsed low mid-nibble → same clean restart.
